// File: rtl/addr_burst_sequencer.sv
// Burst address issuer: queues {base, len} requests and drives one counter index per cycle.
// Optional beat counter output io_beat_count is enabled by defining ADDR_BURST_SEQUENCER_STATS_EN.
module addr_burst_sequencer #(
   parameter int ADDR_W     = 3,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_req_valid,
   output logic              io_req_ready,
   input  logic [ADDR_W-1:0] io_req_addr,
   input  logic [LEN_W-1:0]  io_req_len,
   input  logic              io_hold,
   output logic [31:0]       io_addr,
   output logic              io_addr_valid,
   output logic              io_done,
`ifdef ADDR_BURST_SEQUENCER_STATS_EN
   output logic [31:0]       io_beat_count,
`endif
   output logic              io_busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENT_W = ADDR_W + LEN_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cur;
   logic [LEN_W-1:0]  remaining;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;
   logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];

   logic              push;
   logic              pop;
   logic [ENT_W-1:0]  head;
   logic [ADDR_W-1:0] head_addr;
   logic [LEN_W-1:0]  head_len;

   assign io_req_ready = (count != FULL_CNT);
   assign push         = io_req_valid && io_req_ready;
   assign pop          = !io_hold && (state == IDLE) && (count != '0);
   assign head         = fifo_mem[rd_ptr];
   assign head_addr    = head[ENT_W-1:LEN_W];
   assign head_len     = head[LEN_W-1:0];
   assign io_busy      = (count != '0) || (state == RUN);

   // NOTE: FIFO storage has no reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {io_req_addr, io_req_len};
   end

`ifdef ADDR_BURST_SEQUENCER_STATS_EN
   logic issue;
   assign issue = !io_hold && ((state == RUN) || (pop && head_len != '0));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cur           <= '0;
         remaining     <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         io_addr       <= '0;
         io_addr_valid <= 1'b0;
         io_done       <= 1'b0;
`ifdef ADDR_BURST_SEQUENCER_STATS_EN
         io_beat_count <= '0;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Hold freezes sequencing state but leaves io_addr showing the last beat.
         if (io_hold) begin
            io_addr_valid <= 1'b0;
            io_done       <= 1'b0;
         end else begin
            case (state)
               RUN: begin
                  io_addr       <= {{(32-ADDR_W){1'b0}}, cur};
                  cur           <= cur + 1'b1;
                  remaining     <= remaining - 1'b1;
                  io_addr_valid <= 1'b1;
                  io_done       <= (remaining == LEN_W'(1));
                  if (remaining == LEN_W'(1)) state <= IDLE;
               end
               default: begin
                  if (pop && head_len != '0) begin
                     io_addr       <= {{(32-ADDR_W){1'b0}}, head_addr};
                     cur           <= head_addr + 1'b1;
                     remaining     <= head_len - 1'b1;
                     io_addr_valid <= 1'b1;
                     io_done       <= (head_len == LEN_W'(1));
                     if (head_len != LEN_W'(1)) state <= RUN;
                  end else begin
                     io_addr_valid <= 1'b0;
                     io_done       <= 1'b0;
                  end
               end
            endcase
         end

`ifdef ADDR_BURST_SEQUENCER_STATS_EN
         if (issue) io_beat_count <= io_beat_count + 1'b1;
`endif
      end
   end

endmodule

// File: doc/addr_burst_sequencer.md
# addr_burst_sequencer

Upstream address-issue stage for the 8-entry read-modify-write counter memory. Accepts burst requests (base address, length) over a valid/ready handshake, buffers them in a small FIFO, and drives one address per cycle into the memory stage's 32-bit address port. Each issued beat causes one increment of the addressed counter. Supports back-to-back bursts with zero bubble and a downstream hold.

## Interface
Parameters:
- ADDR_W, 3, index width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 8, burst length field width.
- FIFO_DEPTH, 4, request FIFO entries (power of two).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- io_req_valid  in  1  request present.
- io_req_ready  out  1  FIFO can accept; equals !full.
- io_req_addr  in  ADDR_W  burst base index.
- io_req_len  in  LEN_W  beats in burst; 0 means empty burst.
- io_hold  in  1  downstream stall; no beat issued at an edge where sampled high.
- io_addr  out  32  current beat index, zero-extended; registered.
- io_addr_valid  out  1  io_addr is a live beat; registered.
- io_done  out  1  registered; high during the last beat of each non-empty burst.
- io_busy  out  1  FIFO non-empty or beats remaining.

## Operation
- Reset: FIFO empty, FSM IDLE, io_req_ready=1, io_addr=0, io_addr_valid=0, io_done=0, io_busy=0. Reset mid-burst discards all queued and in-flight beats; no partial io_done.
- Push: when io_req_valid && io_req_ready, {addr, len} written to FIFO tail. Ready depends only on occupancy, never on same-cycle pop.
- FSM states: IDLE (no beats remaining), RUN (remaining > 0).
- Per edge, with hold=0:
  - RUN, remaining > 1: io_addr <= cur, cur <= (cur+1) mod 2^ADDR_W, remaining--, valid=1, done=0.
  - RUN, remaining == 1 (last beat): issue as above with io_done=1; go IDLE.
  - IDLE, FIFO non-empty: pop head; if len > 0, issue beat at base (valid=1, cur <= base+1, remaining <= len-1, done = (len==1)), enter RUN if len > 1; if len == 0, discard, valid=0.
  - IDLE, FIFO empty: valid=0, done=0.
- Back-to-back: in the cycle where the last beat is visible, the FSM is IDLE, so the next edge pops the following request; there is no gap between bursts.
- Hold=1 at an edge: valid<=0, done<=0, io_addr keeps its value, FSM/cur/remaining/FIFO pop frozen. Pushes still accepted.
- Index arithmetic is ADDR_W bits wide; carry discarded (index 7 + 1 -> 0 for ADDR_W=3). Upper 32-ADDR_W bits of io_addr always 0.
- Simultaneous push and pop while non-full: both occur; occupancy unchanged.

## Timing
- Request accepted at edge E: first beat visible after edge E+1 (one cycle of FIFO latency) if the FSM is IDLE and hold=0.
- Burst of length N with no hold: io_addr_valid high for exactly N consecutive cycles; io_done high in the Nth only.
- Zero-length request costs one bubble cycle, with no valid and no done.
- io_busy is combinational from state: high whenever FIFO count > 0 or in RUN.
- Throughput: one beat per cycle sustained across bursts.

## Configuration
- ADDR_BURST_SEQUENCER_STATS_EN: when defined, adds output io_beat_count [31:0], counting issued beats (edges with valid<=1). It wraps at 2^32 and is cleared by reset. When undefined, the port and counter are absent and all other behaviour is identical.

## Test plan
- Reset then a single request addr=2, len=3 -> io_addr 2,3,4 on three consecutive cycles starting one cycle after acceptance; io_done only with 4; io_busy low afterward.
- Wrap: addr=6, len=4 -> io_addr 6,7,0,1; upper bits 0.
- Back-to-back: queue (1,2), (5,1), (0,0), (3,2) -> beats 1,2,5, one bubble, 3,4; io_done on 2, 5 and 4.
- Full FIFO: push 4 requests while hold=1 -> io_req_ready=0 after the 4th push; a 5th valid is not accepted; deasserting hold drains in order.
- Hold mid-burst: addr=0, len=4, hold for 2 cycles after the 2nd beat -> valid drops for 2 cycles; sequence resumes 2,3; done on 3.
- Reset asserted during a beat of (0,8) plus 2 queued requests -> next cycle all outputs at reset values, FIFO empty, no io_done; with STATS_EN, io_beat_count=0.
